shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 95 +++++++++
 tb/tb_shift_add_multiplier.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one ripple-carry adder reused for WIDTH
// shift-and-add iterations; start is accepted only in IDLE and done pulses for one cycle.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     cy;
  logic [2*WIDTH-1:0] shifted;

  assign addend = mq_q[0] ? mcand_q : '0;
  assign cy[0]  = 1'b0;

  // Ripple-carry chain of full-adder cells; carry-out becomes the new MSB after the shift.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]  = acc_hi_q[i] ^ addend[i] ^ cy[i];
    assign cy[i+1] = (acc_hi_q[i] & addend[i]) | (cy[i] & (acc_hi_q[i] ^ addend[i]));
  end

  assign shifted = {cy[WIDTH], sum, mq_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    mq_d      = mq_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mq_d     = b;
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_hi_d = shifted[2*WIDTH-1:WIDTH];
        mq_d     = shifted[WIDTH-1:0];
        count_d  = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          product_d = shifted;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      mq_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      mq_q      <= mq_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboarded bench for shift_add_multiplier at WIDTH=4 and WIDTH=8.
module tb_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rst4_n, rst8_n;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp4_q[$];
  logic [15:0] exp8_q[$];
  logic [7:0]  last4 = '0;
  logic [15:0] last8 = '0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Monitors: pop expected product on each done; otherwise product must hold.
  always @(negedge clk) begin
    if (!rst4_n) begin
      last4 = '0;
      chk("rst4_outputs", {22'd0, busy4, done4, prod4}, 32'd0);
    end else if (done4) begin
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done4 actual=1 required=0 at %0t", $time);
      end else begin
        last4 = exp4_q.pop_front();
        chk("product4", prod4, last4);
      end
    end else begin
      chk("hold4", prod4, last4);
    end
  end

  always @(negedge clk) begin
    if (!rst8_n) begin
      last8 = '0;
      chk("rst8_outputs", {14'd0, busy8, done8, prod8}, 32'd0);
    end else if (done8) begin
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done8 actual=1 required=0 at %0t", $time);
      end else begin
        last8 = exp8_q.pop_front();
        chk("product8", prod8, last8);
      end
    end else begin
      chk("hold8", prod8, last8);
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic mul4(input logic [3:0] x, input logic [3:0] y, input logic [7:0] e);
    int nb;
    a4 = x; b4 = y; start4 = 1'b1;
    @(posedge clk);
    exp4_q.push_back(e);
    #1 start4 = 1'b0;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy4 && !done4) nb++;
    end
    chk("busy4_cycles", nb, 4);
    @(negedge clk);
    chk("done4_latency", {30'd0, done4, busy4}, 32'd2);
    @(posedge clk);
    #1;
  endtask

  task automatic mul8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    int nb;
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk);
    exp8_q.push_back(e);
    #1 start8 = 1'b0;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy8 && !done8) nb++;
    end
    chk("busy8_cycles", nb, 8);
    @(negedge clk);
    chk("done8_latency", {30'd0, done8, busy8}, 32'd2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int last_acc, n_acc, n_done;
    logic prevb;
    rst4_n = 1'b0; rst8_n = 1'b0;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    #1;
    chk("reset4_async", {22'd0, busy4, done4, prod4}, 32'd0);
    chk("reset8_async", {14'd0, busy8, done8, prod8}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst4_n = 1'b1; rst8_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed WIDTH=4 vectors.
    mul4(4'd15, 4'd15, 8'hE1);
    repeat (3) @(negedge clk);
    chk("product4_held", prod4, 8'hE1);
    @(posedge clk); #1;
    mul4(4'd13, 4'd11, 8'h8F);

    // Reset during the second iteration aborts without a done.
    a4 = 4'd9; b4 = 4'd5; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    #2 rst4_n = 1'b0;
    #1 chk("abort4_outputs", {22'd0, busy4, done4, prod4}, 32'd0);
    #4 rst4_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    mul4(4'd3, 4'd4, 8'd12);
    mul4(4'd0, 4'd9, 8'd0);

    // start pulses during CALC and DONE must be ignored.
    a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
    @(posedge clk);
    exp4_q.push_back(8'd42);
    #1 start4 = 1'b0;
    @(posedge clk);
    #1 a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    chk("ignored_start_busy4", {31'd0, busy4}, 32'd0);
    @(posedge clk); #1;
    mul4(4'd1, 4'd1, 8'd1);

    // start held high: accepts every 6 edges, one done per run.
    repeat (3) exp4_q.push_back(8'd15);
    a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
    prevb = 1'b0; last_acc = 0; n_acc = 0; n_done = 0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      if (busy4 && !prevb) begin
        if (n_acc > 0) chk("b2b_spacing", cyc - last_acc, 6);
        last_acc = cyc;
        n_acc++;
      end
      prevb = busy4;
      if (done4) n_done++;
    end
    start4 = 1'b0;
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_dones", n_done, 3);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        mul4(4'(i), 4'(j), 8'(i * j));

    // WIDTH=8.
    mul8(8'd255, 8'd255, 16'hFE01);
    mul8(8'd200, 8'd3, 16'd600);
    for (int n = 0; n < 1000; n++) begin
      int x, y;
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      mul8(8'(x), 8'(y), 16'(x * y));
    end

    repeat (3) @(posedge clk);
    checks++;
    if (exp4_q.size() != 0 || exp8_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results actual=%0d required=0", exp4_q.size() + exp8_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
